// File: rtl/irq_timer_pkg.sv
// Shared definitions for the interrupt timer: register map, CTRL field
// positions, MODE codes and FSM state encoding.
package irq_timer_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'b00;
   localparam logic [1:0] ADDR_PRESET = 2'b01;
   localparam logic [1:0] ADDR_COUNT  = 2'b10;
   localparam logic [1:0] ADDR_UNUSED = 2'b11;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

endpackage

// File: rtl/irq_timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable level interrupt.
module irq_timer
   import irq_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_ctrl;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_iflag;

   logic [31:0] w_count_nxt;
   logic        w_iflag_nxt;
   logic        w_en_clr;
   logic        w_ctrl_wr;
   logic        w_preset_wr;
   logic [1:0]  w_mode;

   assign w_ctrl_wr   = we && (addr == ADDR_CTRL);
   assign w_preset_wr = we && (addr == ADDR_PRESET);
   assign w_mode      = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_iflag_nxt = r_iflag;
      w_en_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_ctrl[CTRL_EN]) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = ST_CNT;
         end
         ST_CNT: begin
            // COUNT of 0 or 1 both expire, so PRESET=0 acts like PRESET=1
            if (!r_ctrl[CTRL_EN]) begin
               w_state_nxt = ST_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               w_count_nxt = '0;
               w_iflag_nxt = 1'b1;
               w_state_nxt = ST_INT;
            end
         end
         ST_INT: begin
            if (w_mode == MODE_AUTO) begin
               w_iflag_nxt = 1'b0;
               w_state_nxt = ST_LOAD;
            end else begin
               w_en_clr    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ctrl   <= '0;
         r_preset <= '0;
         r_count  <= '0;
         r_iflag  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         // A CPU write to CTRL takes priority over FSM updates of EN and IFLAG
         if (w_ctrl_wr) begin
            r_ctrl  <= wdata[3:0];
            r_iflag <= 1'b0;
         end else begin
            r_iflag <= w_iflag_nxt;
            if (w_en_clr) r_ctrl[CTRL_EN] <= 1'b0;
         end
         if (w_preset_wr) r_preset <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_CTRL:   rdata = {28'd0, r_ctrl};
         ADDR_PRESET: rdata = r_preset;
         ADDR_COUNT:  rdata = r_count;
         default:     rdata = '0;
      endcase
   end

   assign irq = r_iflag & r_ctrl[CTRL_IM];

endmodule

// File: tb/tb_irq_timer.sv
// Scenario bench for irq_timer: per-cycle COUNT/irq expectations are queued
// when stimulus is driven and compared as the DUT produces each cycle.
module tb_irq_timer;
   import irq_timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] cnt;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   irq_timer dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // One clock edge with the given bus cycle; leaves addr on COUNT, settled.
   task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
      we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0; addr = ADDR_COUNT; wdata = '0;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, ADDR_CTRL, '0);
      step(1'b0, ADDR_CTRL, '0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b1, ADDR_CTRL, 32'hF);
      step(1'b1, ADDR_PRESET, 32'h55);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a);
         #1;
         n_vec++;
         if (rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reg[%0d]: got %h, required 0", a, rdata);
         end
      end
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL reset_irq: got %b, required 0", irq);
      end
   endtask

   task automatic test_oneshot();
      int cnt_tab[7] = '{0, 3, 2, 1, 0, 0, 0};
      bit irq_tab[7] = '{0, 0, 0, 0, 1, 1, 1};
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd3);
      step(1'b1, ADDR_CTRL, 32'h9);
      for (int k = 0; k < 7; k++) exp_q.push_back('{32'(cnt_tab[k]), irq_tab[k]});
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL oneshot[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
      addr = ADDR_CTRL;
      #1;
      n_vec++;
      if (rdata !== 32'h8) begin
         n_err++;
         $display("FAIL oneshot_ctrl: got %h, required 00000008", rdata);
      end
   endtask

   task automatic test_ack();
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back('{32'd0, 1'b0});
         if (k == 0) step(1'b1, ADDR_CTRL, 32'h8);
         else        step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL ack[%0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
   endtask

   task automatic test_auto_reload();
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd2);
      step(1'b1, ADDR_CTRL, 32'hB);
      for (int k = 1; k <= 13; k++)
         exp_q.push_back('{(k % 4 == 2) ? 32'd2 : (k % 4 == 3) ? 32'd1 : 32'd0, (k % 4 == 0)});
      for (int k = 1; k <= 13; k++) begin
         step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL auto[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
      addr = ADDR_CTRL;
      #1;
      n_vec++;
      if (rdata !== 32'hB) begin
         n_err++;
         $display("FAIL auto_ctrl: got %h, required 0000000b", rdata);
      end
   endtask

   task automatic test_mask();
      int cnt_tab[8] = '{0, 2, 1, 0, 0, 0, 0, 0};
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd2);
      step(1'b1, ADDR_CTRL, 32'h1);
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back('{32'(cnt_tab[k-1]), 1'b0});
         step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL mask[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
      addr = ADDR_CTRL;
      #1;
      n_vec++;
      if (rdata !== 32'h0) begin
         n_err++;
         $display("FAIL mask_ctrl: got %h, required 00000000", rdata);
      end
   endtask

   task automatic test_preset_zero();
      bit irq_tab[4] = '{0, 0, 1, 1};
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd0);
      step(1'b1, ADDR_CTRL, 32'h9);
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back('{32'd0, irq_tab[k-1]});
         step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL preset0[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
   endtask

   // CTRL write on the INT edge keeps EN=1 and clears IFLAG, so a new run starts.
   task automatic test_ctrl_write_wins();
      int cnt_tab[8] = '{0, 3, 2, 1, 0, 0, 0, 3};
      bit irq_tab[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd3);
      step(1'b1, ADDR_CTRL, 32'h9);
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back('{32'(cnt_tab[k-1]), irq_tab[k-1]});
         if (k == 6) step(1'b1, ADDR_CTRL, 32'h9);
         else        step(1'b0, ADDR_COUNT, '0);
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL wins[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
      addr = ADDR_CTRL;
      #1;
      n_vec++;
      if (rdata !== 32'h9) begin
         n_err++;
         $display("FAIL wins_ctrl: got %h, required 00000009", rdata);
      end
   endtask

   // Stop lands on the edge where COUNT becomes 6; PRESET=20 written mid-count
   // only shows up after the restart's LOAD.
   task automatic test_stop_preset();
      int cnt_tab[14] = '{0, 10, 9, 8, 7, 6, 6, 6, 6, 6, 6, 6, 20, 19};
      exp_t e;
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd10);
      step(1'b1, ADDR_CTRL, 32'h9);
      for (int k = 1; k <= 14; k++) begin
         exp_q.push_back('{32'(cnt_tab[k-1]), 1'b0});
         case (k)
            4:       step(1'b1, ADDR_PRESET, 32'd20);
            6:       step(1'b1, ADDR_CTRL, 32'h8);
            11:      step(1'b1, ADDR_CTRL, 32'h9);
            default: step(1'b0, ADDR_COUNT, '0);
         endcase
         e = exp_q.pop_front();
         n_vec++;
         if (rdata !== e.cnt || irq !== e.irq) begin
            n_err++;
            $display("FAIL stop[edge %0d]: count=%0d irq=%b, required count=%0d irq=%b",
                     k, rdata, irq, e.cnt, e.irq);
         end
      end
   endtask

   task automatic test_reset_mid_count();
      do_reset();
      step(1'b1, ADDR_PRESET, 32'd7);
      step(1'b1, ADDR_CTRL, 32'hB);
      for (int k = 1; k <= 4; k++) step(1'b0, ADDR_COUNT, '0);
      n_vec++;
      if (rdata !== 32'd5) begin
         n_err++;
         $display("FAIL midreset_pre: count=%0d, required 5", rdata);
      end
      reset = 1'b1;
      step(1'b1, ADDR_CTRL, 32'hF);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a);
         #1;
         n_vec++;
         if (rdata !== 32'd0) begin
            n_err++;
            $display("FAIL midreset_reg[%0d]: got %h, required 0", a, rdata);
         end
      end
      n_vec++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_irq: got %b, required 0", irq);
      end
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; addr = ADDR_CTRL; wdata = '0;
      test_reset();
      test_oneshot();
      test_ack();
      test_auto_reload();
      test_mask();
      test_preset_zero();
      test_ctrl_write_wins();
      test_stop_preset();
      test_reset_mid_count();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
